fifo_ptr_ctrl: RTL and testbench

Parametrised successor to the 8-entry FIFO address controller. It generates read and write addresses for an external dual-port RAM buffering sparse-matrix operands. It adds concurrent read and write, an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow error flags and a registered read-valid strobe for synchronous RAM.

---
 rtl/fifo_ptr_ctrl.sv | 98 +++++++++
 tb/tb_fifo_ptr_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Read/write address controller for an external dual-port RAM FIFO.
// Provides occupancy, threshold flags, flush, sticky error flags and a registered read-valid strobe.
module fifo_ptr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 2**ADDR_W - 1,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic              r_en,
    input  logic              flush,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              wr_ok,
    output logic              rd_ok,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

    logic [ADDR_W:0] wptr_reg, wptr_next;
    logic [ADDR_W:0] rptr_reg, rptr_next;
    logic            overflow_reg, overflow_next;
    logic            underflow_reg, underflow_next;
    logic            rd_valid_reg, rd_valid_next;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign count        = wptr_reg - rptr_reg;
    assign empty        = (wptr_reg == rptr_reg);
    assign full         = (wptr_reg[ADDR_W] != rptr_reg[ADDR_W]) &&
                          (wptr_reg[ADDR_W-1:0] == rptr_reg[ADDR_W-1:0]);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_ok    = w_en & ~full & ~flush;
    assign rd_ok    = r_en & ~empty & ~flush;
    assign waddr    = wptr_reg[ADDR_W-1:0];
    assign raddr    = rptr_reg[ADDR_W-1:0];
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign rd_valid  = rd_valid_reg;

    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        rd_valid_next  = rd_ok;
        if (flush) begin
            wptr_next      = '0;
            rptr_next      = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
            rd_valid_next  = 1'b0;
        end else begin
            if (wr_ok)
                wptr_next = wptr_reg + 1'b1;
            if (rd_ok)
                rptr_next = rptr_reg + 1'b1;
            // A fresh error in the same cycle as clr_err keeps the flag set.
            if (w_en && full)
                overflow_next = 1'b1;
            else if (clr_err)
                overflow_next = 1'b0;
            if (r_en && empty)
                underflow_next = 1'b1;
            else if (clr_err)
                underflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            rd_valid_reg  <= rd_valid_next;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: directed scenarios plus randomized traffic
// against a model that tracks total writes/reads accepted.
module tb_fifo_ptr_ctrl;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AF     = 7;
    localparam int AE     = 1;

    logic              clk = 1'b0;
    logic              rst, w_en, r_en, flush, clr_err;
    logic [ADDR_W-1:0] waddr, raddr;
    logic              wr_ok, rd_ok, rd_valid;
    logic [ADDR_W:0]   count;
    logic              full, empty, almost_full, almost_empty, overflow, underflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: totals of accepted writes/reads since last clear, plus sticky flags.
    int m_wcnt, m_rcnt;
    bit m_ovf, m_unf, m_rdv;

    fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .flush(flush), .clr_err(clr_err),
        .waddr(waddr), .raddr(raddr), .wr_ok(wr_ok), .rd_ok(rd_ok), .rd_valid(rd_valid),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic int occ();
        return m_wcnt - m_rcnt;
    endfunction

    function automatic void model_clear();
        m_wcnt = 0; m_rcnt = 0; m_ovf = 0; m_unf = 0; m_rdv = 0;
    endfunction

    task automatic set_in(input bit w, input bit r, input bit f, input bit c);
        w_en = w; r_en = r; flush = f; clr_err = c;
    endtask

    // Advance one clock and apply the FIFO rules to the model; ends at the next falling edge.
    task automatic tick();
        int o;
        bit acc_w, acc_r;
        o     = occ();
        acc_w = w_en && !flush && (o < DEPTH);
        acc_r = r_en && !flush && (o > 0);
        $display("txn %0d: w=%0d r=%0d fl=%0d ce=%0d | wr_ok=%0d rd_ok=%0d cnt=%0d wa=%0d ra=%0d",
                 cyc, w_en, r_en, flush, clr_err, wr_ok, rd_ok, count, waddr, raddr);
        @(posedge clk);
        cyc++;
        if (flush) begin
            model_clear();
        end else begin
            if (w_en && o == DEPTH) m_ovf = 1; else if (clr_err) m_ovf = 0;
            if (r_en && o == 0)     m_unf = 1; else if (clr_err) m_unf = 0;
            m_wcnt += int'(acc_w);
            m_rcnt += int'(acc_r);
            m_rdv   = acc_r;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({count, empty, full, almost_empty, almost_full, overflow, underflow, rd_valid, waddr, raddr}
            !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d e=%0d f=%0d ae=%0d af=%0d ov=%0d un=%0d rv=%0d wa=%0d ra=%0d required cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0 rv=0 wa=0 ra=0",
                     count, empty, full, almost_empty, almost_full, overflow, underflow, rd_valid, waddr, raddr);
        end
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 9; i++) begin
            set_in(1, 0, 0, 0);
            #1;
            checks++;
            if (wr_ok !== (i <= DEPTH)) begin
                errors++;
                $display("FAIL fill_wr_ok[%0d]: got %0d required %0d", i, wr_ok, (i <= DEPTH));
            end
            #1;
            tick();
            checks++;
            if (count !== 4'(occ()) || almost_full !== (occ() >= AF) || full !== (occ() == DEPTH)) begin
                errors++;
                $display("FAIL fill_level[%0d]: cnt=%0d af=%0d full=%0d required cnt=%0d af=%0d full=%0d",
                         i, count, almost_full, full, occ(), (occ() >= AF), (occ() == DEPTH));
            end
        end
        set_in(0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || waddr !== 3'd0 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_end: cnt=%0d ov=%0d wa=%0d af=%0d required cnt=8 ov=1 wa=0 af=1",
                     count, overflow, waddr, almost_full);
        end
        #1;
    endtask

    task automatic test_full_rw();
        set_in(1, 1, 0, 0);
        #1;
        checks++;
        if (rd_ok !== 1'b1 || wr_ok !== 1'b0) begin
            errors++;
            $display("FAIL full_rw_ok: rd_ok=%0d wr_ok=%0d required rd_ok=1 wr_ok=0", rd_ok, wr_ok);
        end
        #1;
        tick();
        set_in(0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 4'd7 || full !== 1'b0 || overflow !== 1'b1 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_after: cnt=%0d full=%0d ov=%0d rv=%0d required cnt=7 full=0 ov=1 rv=1",
                     count, full, overflow, rd_valid);
        end
        #1;
    endtask

    task automatic test_empty();
        set_in(0, 0, 1, 0);
        tick();
        set_in(0, 1, 0, 0);
        #1;
        checks++;
        if (rd_ok !== 1'b0) begin
            errors++;
            $display("FAIL empty_rd_ok: got %0d required 0", rd_ok);
        end
        tick();
        set_in(1, 1, 0, 0);
        #1;
        checks++;
        if (underflow !== 1'b1 || wr_ok !== 1'b1 || rd_ok !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw: un=%0d wr_ok=%0d rd_ok=%0d required un=1 wr_ok=1 rd_ok=0",
                     underflow, wr_ok, rd_ok);
        end
        tick();
        set_in(0, 0, 0, 1);
        #1;
        checks++;
        if (count !== 4'd1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL empty_after: cnt=%0d un=%0d required cnt=1 un=1", count, underflow);
        end
        tick();
        set_in(0, 0, 0, 0);
        #1;
        checks++;
        if (underflow !== 1'b0 || count !== 4'd1) begin
            errors++;
            $display("FAIL clr_err: un=%0d cnt=%0d required un=0 cnt=1", underflow, count);
        end
        #1;
    endtask

    task automatic test_wrap();
        set_in(0, 0, 1, 0);
        tick();
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int k = 0; k < 10; k++) begin
                set_in(k < 5, k >= 5, 0, 0);
                #1;
                checks++;
                if (waddr !== 3'(m_wcnt % DEPTH) || raddr !== 3'(m_rcnt % DEPTH) || count > 4'd5) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d.%0d]: wa=%0d ra=%0d cnt=%0d required wa=%0d ra=%0d cnt<=5",
                             rnd, k, waddr, raddr, count, m_wcnt % DEPTH, m_rcnt % DEPTH);
                end
                tick();
            end
            set_in(0, 0, 0, 0);
            #1;
            checks++;
            if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
                errors++;
                $display("FAIL wrap_round[%0d]: e=%0d ov=%0d un=%0d required e=1 ov=0 un=0",
                         rnd, empty, overflow, underflow);
            end
            #1;
        end
        checks++;
        if (waddr !== 3'd7 || raddr !== 3'd7) begin
            errors++;
            $display("FAIL wrap_end: wa=%0d ra=%0d required wa=7 ra=7", waddr, raddr);
        end
    endtask

    task automatic test_back_to_back();
        int w0, r0;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0);
            tick();
        end
        w0 = m_wcnt; r0 = m_rcnt;
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, 0, 0);
            #1;
            checks++;
            if (count !== 4'd4 || wr_ok !== 1'b1 || rd_ok !== 1'b1 || (i > 0 && rd_valid !== 1'b1)) begin
                errors++;
                $display("FAIL stream[%0d]: cnt=%0d wr_ok=%0d rd_ok=%0d rv=%0d required cnt=4 wr_ok=1 rd_ok=1 rv=1",
                         i, count, wr_ok, rd_ok, rd_valid);
            end
            tick();
        end
        set_in(0, 0, 0, 0);
        #1;
        checks++;
        if (waddr !== 3'((w0 + 20) % DEPTH) || raddr !== 3'((r0 + 20) % DEPTH) || count !== 4'd4) begin
            errors++;
            $display("FAIL stream_end: wa=%0d ra=%0d cnt=%0d required wa=%0d ra=%0d cnt=4",
                     waddr, raddr, count, (w0 + 20) % DEPTH, (r0 + 20) % DEPTH);
        end
        #1;
    endtask

    task automatic test_flush();
        while (occ() < DEPTH) begin
            set_in(1, 0, 0, 0);
            tick();
        end
        set_in(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 0, 0);
            tick();
        end
        set_in(1, 0, 1, 0);
        #1;
        checks++;
        if (wr_ok !== 1'b0 || count !== 4'd6 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: wr_ok=%0d cnt=%0d ov=%0d required wr_ok=0 cnt=6 ov=1",
                     wr_ok, count, overflow);
        end
        tick();
        set_in(0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || waddr !== 3'd0 || raddr !== 3'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: cnt=%0d e=%0d ov=%0d wa=%0d ra=%0d rv=%0d required cnt=0 e=1 ov=0 wa=0 ra=0 rv=0",
                     count, empty, overflow, waddr, raddr, rd_valid);
        end
        #1;
    endtask

    task automatic test_async_rst();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: cnt=%0d e=%0d required cnt=0 e=1", count, empty);
        end
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_random();
        bit w, r, f, c;
        bit ew, er;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < 8);
            set_in(w, r, f, c);
            ew = w && !f && (occ() < DEPTH);
            er = r && !f && (occ() > 0);
            #1;
            checks++;
            if ({wr_ok, rd_ok, rd_valid} !== {ew, er, m_rdv}) begin
                errors++;
                $display("FAIL rand_ok[%0d]: wr_ok/rd_ok/rv=%b required %b", i, {wr_ok, rd_ok, rd_valid}, {ew, er, m_rdv});
            end
            checks++;
            if (count !== 4'(occ()) || waddr !== 3'(m_wcnt % DEPTH) || raddr !== 3'(m_rcnt % DEPTH)) begin
                errors++;
                $display("FAIL rand_ptr[%0d]: cnt=%0d wa=%0d ra=%0d required cnt=%0d wa=%0d ra=%0d",
                         i, count, waddr, raddr, occ(), m_wcnt % DEPTH, m_rcnt % DEPTH);
            end
            checks++;
            if ({full, empty, almost_full, almost_empty, overflow, underflow} !==
                {occ() == DEPTH, occ() == 0, occ() >= AF, occ() <= AE, m_ovf, m_unf}) begin
                errors++;
                $display("FAIL rand_flags[%0d]: f/e/af/ae/ov/un=%b required %b", i,
                         {full, empty, almost_full, almost_empty, overflow, underflow},
                         {occ() == DEPTH, occ() == 0, occ() >= AF, occ() <= AE, m_ovf, m_unf});
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_fill();
        test_full_rw();
        test_empty();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_async_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
